// File: rtl/wb_stream_reader_cfg_mc_pkg.sv
// Shared register map, CTRL bit positions and channel state codes for the
// multi-channel stream-reader configuration block.
package wb_stream_reader_cfg_mc_pkg;

    // Global region register indices (wb_adr_i[4:2] with region 0).
    localparam logic [2:0] REG_IRQ_STATUS = 3'd0;
    localparam logic [2:0] REG_IRQ_MASK   = 3'd1;
    localparam logic [2:0] REG_BUSY       = 3'd2;
    localparam logic [2:0] REG_INFO       = 3'd3;

    // Per-channel register indices.
    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_START_ADR  = 3'd1;
    localparam logic [2:0] REG_BUF_SIZE   = 3'd2;
    localparam logic [2:0] REG_BURST_SIZE = 3'd3;
    localparam logic [2:0] REG_TX_BYTES   = 3'd4;
    localparam logic [2:0] REG_DONE_CNT   = 3'd5;

    localparam int CTRL_START     = 0;
    localparam int CTRL_CONT      = 1;
    localparam int CTRL_ABORT     = 2;
    localparam int CTRL_START_IGN = 16;

    localparam logic [7:0] INFO_VERSION = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } ch_state_e;

    // CTRL readback: START/ABORT always read 0, state in b9:8, START_IGN in b16.
    function automatic logic [31:0] ctrl_word(input ch_state_e st, input logic cont,
                                              input logic ign);
        return {15'd0, ign, 6'd0, st, 5'd0, 1'b0, cont, 1'b0};
    endfunction

endpackage

// File: rtl/wb_stream_reader_cfg_mc_ch.sv
// One DMA channel: config registers, start/abort FSM with optional
// auto-restart, completion counter and sticky ignored-start flag.
module wb_stream_reader_cfg_mc_ch
    import wb_stream_reader_cfg_mc_pkg::*;
#(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busy_i,
    input  logic             wr_i,
    input  logic [2:0]       reg_i,
    input  logic [WB_DW-1:0] dat_i,
    output ch_state_e        state_o,
    output logic             cont_o,
    output logic             start_ign_o,
    output logic [15:0]      done_cnt_o,
    output logic [WB_AW-1:0] start_adr_o,
    output logic [WB_AW-1:0] buf_size_o,
    output logic [WB_AW-1:0] burst_size_o,
    output logic             enable_o,
    output logic             done_o
);

    ch_state_e        state_q, state_d;
    logic             cont_q, cont_d;
    logic             abort_pend_q, abort_pend_d;
    logic             start_ign_q, start_ign_d;
    logic             busy_r_q, busy_r_d;
    logic             enable_q, enable_d;
    logic [15:0]      done_cnt_q, done_cnt_d;
    logic [WB_AW-1:0] start_adr_q, start_adr_d;
    logic [WB_AW-1:0] buf_size_q, buf_size_d;
    logic [WB_AW-1:0] burst_size_q, burst_size_d;

    logic ctrl_wr, start_cmd, abort_cmd, busy_fall;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d      = state_q;
        cont_d       = cont_q;
        abort_pend_d = abort_pend_q;
        start_ign_d  = start_ign_q;
        done_cnt_d   = done_cnt_q;
        start_adr_d  = start_adr_q;
        buf_size_d   = buf_size_q;
        burst_size_d = burst_size_q;
        busy_r_d     = busy_i;
        done_o       = 1'b0;

        ctrl_wr   = wr_i && (reg_i == REG_CTRL);
        start_cmd = ctrl_wr && dat_i[CTRL_START];
        abort_cmd = ctrl_wr && dat_i[CTRL_ABORT];
        busy_fall = busy_r_q && !busy_i;

        if (ctrl_wr) begin
            cont_d = dat_i[CTRL_CONT];
            if (dat_i[CTRL_START_IGN]) start_ign_d = 1'b0;
        end
        if (wr_i) begin
            case (reg_i)
                REG_START_ADR:  start_adr_d  = WB_AW'(dat_i);
                REG_BUF_SIZE:   buf_size_d   = WB_AW'(dat_i);
                REG_BURST_SIZE: burst_size_d = WB_AW'(dat_i);
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: if (start_cmd && !abort_cmd) state_d = ST_ARM;
            ST_ARM: begin
                if (abort_cmd)   state_d = ST_IDLE;
                else if (busy_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Abort cannot stop a running transfer; it only cancels the restart.
                if (abort_cmd) abort_pend_d = 1'b1;
                if (busy_fall) begin
                    state_d    = ST_DONE;
                    done_o     = 1'b1;
                    done_cnt_d = done_cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d      = (cont_q && !abort_pend_q && !abort_cmd) ? ST_ARM : ST_IDLE;
                abort_pend_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_cmd && !abort_cmd && (state_q != ST_IDLE)) start_ign_d = 1'b1;

        enable_d = (state_d == ST_ARM) && (state_q != ST_ARM);
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            cont_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            start_ign_q  <= 1'b0;
            busy_r_q     <= 1'b0;
            enable_q     <= 1'b0;
            done_cnt_q   <= '0;
            start_adr_q  <= '0;
            buf_size_q   <= '0;
            burst_size_q <= '0;
        end else begin
            state_q      <= state_d;
            cont_q       <= cont_d;
            abort_pend_q <= abort_pend_d;
            start_ign_q  <= start_ign_d;
            busy_r_q     <= busy_r_d;
            enable_q     <= enable_d;
            done_cnt_q   <= done_cnt_d;
            start_adr_q  <= start_adr_d;
            buf_size_q   <= buf_size_d;
            burst_size_q <= burst_size_d;
        end
    end

    assign state_o      = state_q;
    assign cont_o       = cont_q;
    assign start_ign_o  = start_ign_q;
    assign done_cnt_o   = done_cnt_q;
    assign start_adr_o  = start_adr_q;
    assign buf_size_o   = buf_size_q;
    assign burst_size_o = burst_size_q;
    assign enable_o     = enable_q;

endmodule

// File: rtl/wb_stream_reader_cfg_mc.sv
// Wishbone config/status front end for NCH stream-reader channels: bus decode,
// ack/err generation, shared IRQ status/mask and the register read mux.
module wb_stream_reader_cfg_mc
    import wb_stream_reader_cfg_mc_pkg::*;
#(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32,
    parameter int NCH   = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [7:0]           wb_adr_i,
    input  logic [WB_DW-1:0]     wb_dat_i,
    input  logic [WB_DW/8-1:0]   wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic [2:0]           wb_cti_i,
    input  logic [1:0]           wb_bte_i,
    output logic [WB_DW-1:0]     wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 wb_rty_o,
    output logic                 irq,
    input  logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       enable,
    input  logic [NCH*WB_DW-1:0] tx_cnt,
    output logic [NCH*WB_AW-1:0] start_adr,
    output logic [NCH*WB_AW-1:0] buf_size,
    output logic [NCH*WB_AW-1:0] burst_size
);

    logic [2:0]     region, reg_idx;
    logic           mapped, req, wr_en;
    logic           ack_q, ack_d, err_q, err_d, irq_q, irq_d;
    logic [NCH-1:0] status_q, status_d, mask_q, mask_d;
    logic [WB_DW-1:0] rd_data;

    ch_state_e      ch_state [NCH];
    logic [NCH-1:0] ch_cont, ch_ign, ch_done;
    logic [15:0]    ch_done_cnt [NCH];

    logic unused_inputs;
    assign unused_inputs = ^{wb_sel_i, wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

    assign region  = wb_adr_i[7:5];
    assign reg_idx = wb_adr_i[4:2];

    always_comb begin
        mapped = 1'b0;
        if (region == 3'd0)          mapped = (reg_idx <= REG_INFO);
        else if (int'(region) <= NCH) mapped = (reg_idx <= REG_DONE_CNT);
    end

    // The ack_q/err_q terms force an idle cycle between back-to-back accesses.
    assign req   = wb_cyc_i && wb_stb_i && !ack_q && !err_q;
    assign wr_en = ack_q && wb_cyc_i && wb_stb_i && wb_we_i;

    always_comb begin
        ack_d    = req && mapped;
        err_d    = req && !mapped;
        status_d = status_q;
        mask_d   = mask_q;
        if (wr_en && region == 3'd0 && reg_idx == REG_IRQ_STATUS)
            status_d = status_q & ~wb_dat_i[NCH-1:0];
        if (wr_en && region == 3'd0 && reg_idx == REG_IRQ_MASK)
            mask_d = wb_dat_i[NCH-1:0];
        // A completion in the same cycle as a W1C keeps the bit set.
        status_d = status_d | ch_done;
        irq_d    = |(status_q & mask_q);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            status_q <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            err_q    <= err_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        wb_stream_reader_cfg_mc_ch #(
            .WB_AW(WB_AW),
            .WB_DW(WB_DW)
        ) u_ch (
            .clk          (wb_clk_i),
            .rst          (wb_rst_i),
            .busy_i       (busy[n]),
            .wr_i         (wr_en && (int'(region) == n + 1)),
            .reg_i        (reg_idx),
            .dat_i        (wb_dat_i),
            .state_o      (ch_state[n]),
            .cont_o       (ch_cont[n]),
            .start_ign_o  (ch_ign[n]),
            .done_cnt_o   (ch_done_cnt[n]),
            .start_adr_o  (start_adr[n*WB_AW +: WB_AW]),
            .buf_size_o   (buf_size[n*WB_AW +: WB_AW]),
            .burst_size_o (burst_size[n*WB_AW +: WB_AW]),
            .enable_o     (enable[n]),
            .done_o       (ch_done[n])
        );
    end

    always_comb begin
        rd_data = '0;
        if (region == 3'd0) begin
            case (reg_idx)
                REG_IRQ_STATUS: rd_data = WB_DW'(status_q);
                REG_IRQ_MASK:   rd_data = WB_DW'(mask_q);
                REG_BUSY:       rd_data = WB_DW'(busy);
                REG_INFO:       rd_data = WB_DW'({INFO_VERSION, 16'd0, 8'(NCH)});
                default:        rd_data = '0;
            endcase
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (int'(region) == n + 1) begin
                    case (reg_idx)
                        REG_CTRL:       rd_data = WB_DW'(ctrl_word(ch_state[n], ch_cont[n], ch_ign[n]));
                        REG_START_ADR:  rd_data = WB_DW'(start_adr[n*WB_AW +: WB_AW]);
                        REG_BUF_SIZE:   rd_data = WB_DW'(buf_size[n*WB_AW +: WB_AW]);
                        REG_BURST_SIZE: rd_data = WB_DW'(burst_size[n*WB_AW +: WB_AW]);
                        REG_TX_BYTES:   rd_data = tx_cnt[n*WB_DW +: WB_DW] << 2;
                        REG_DONE_CNT:   rd_data = WB_DW'(ch_done_cnt[n]);
                        default:        rd_data = '0;
                    endcase
                end
            end
        end
    end

    assign wb_dat_o = rd_data;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;
    assign irq      = irq_q;

endmodule

// File: tb/tb_wb_stream_reader_cfg_mc.sv
// Randomized self-checking bench for wb_stream_reader_cfg_mc against a
// register-level reference model of the channel/IRQ behaviour.
module tb_wb_stream_reader_cfg_mc;

    localparam int NCH = 4;
    localparam logic [7:0] A_STATUS = 8'h00, A_MASK = 8'h04, A_BUSY = 8'h08, A_INFO = 8'h0C;
    localparam int R_CTRL = 0, R_TX = 4, R_DONE = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      wb_adr_i = '0;
    logic [31:0]     wb_dat_i = '0;
    logic [3:0]      wb_sel_i = 4'hF;
    logic            wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
    logic [2:0]      wb_cti_i = '0;
    logic [1:0]      wb_bte_i = '0;
    logic [31:0]     wb_dat_o;
    logic            wb_ack_o, wb_err_o, wb_rty_o, irq;
    logic [NCH-1:0]  busy = '0;
    logic [NCH-1:0]  enable;
    logic [NCH*32-1:0] tx_cnt = '0;
    logic [NCH*32-1:0] start_adr, buf_size, burst_size;

    wb_stream_reader_cfg_mc #(.WB_AW(32), .WB_DW(32), .NCH(NCH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .irq(irq), .busy(busy), .enable(enable),
        .tx_cnt(tx_cnt), .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents and completion bookkeeping.
    logic [31:0] m_cfg [NCH][3];
    int          m_done [NCH];
    logic [3:0]  m_status = '0;
    logic [3:0]  m_mask = '0;

    // Enable pulse monitor: counts pulses, flags any pulse longer than one cycle.
    int             en_cnt [NCH];
    int             dbl_pulse = 0;
    logic [NCH-1:0] en_prev = '0;
    always @(posedge clk) begin
        for (int n = 0; n < NCH; n++) if (enable[n] === 1'b1) en_cnt[n] <= en_cnt[n] + 1;
        dbl_pulse <= dbl_pulse + $countones(enable & en_prev);
        en_prev   <= enable;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] ch_adr(input int n, input int r);
        return 8'((n + 1) * 32 + r * 4);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic bus(input logic [7:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd_o, output logic got_ack, output logic got_err);
        int n = 0;
        wb_adr_i = a; wb_we_i = w; wb_dat_i = d; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!(wb_ack_o || wb_err_o) && n < 8);
        got_ack = wb_ack_o; got_err = wb_err_o; rd_o = wb_dat_o;
        if (!(got_ack || got_err)) begin
            errors++;
            $display("FAIL bus_timeout adr=%h: no ack or err within 8 cycles", a);
        end
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        logic unused_ack, unused_err;
        bus(a, 1'b1, d, unused_rd, unused_ack, unused_err);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] r);
        logic unused_ack, unused_err;
        bus(a, 1'b0, 32'd0, r, unused_ack, unused_err);
    endtask

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_done[n] = 0;
            for (int k = 0; k < 3; k++) m_cfg[n][k] = '0;
        end
        m_status = '0; m_mask = '0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        cycles(3);
        checks++;
        if (enable !== '0 || irq !== 1'b0 || wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: enable=%b irq=%b ack=%b err=%b, need all 0", enable, irq, wb_ack_o, wb_err_o);
        end
        rst = 1'b0;
        model_reset();
        cycles(1);
        rd(A_INFO, r); checks++;
        if (r !== {8'h02, 16'd0, 8'(NCH)}) begin errors++; $display("FAIL info: got %h need %h", r, {8'h02, 16'd0, 8'(NCH)}); end
        rd(A_STATUS, r); checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL reset_status: got %h need 0", r); end
        rd(A_MASK, r); checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL reset_mask: got %h need 0", r); end
        rd(A_BUSY, r); checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h need 0", r); end
        for (int n = 0; n < NCH; n++) begin
            for (int k = 0; k <= R_DONE; k++) begin
                rd(ch_adr(n, k), r); checks++;
                if (r !== 32'd0) begin errors++; $display("FAIL reset_ch%0d_reg%0d: got %h need 0", n, k, r); end
            end
        end
        checks++;
        if (start_adr !== '0 || buf_size !== '0 || burst_size !== '0) begin
            errors++; $display("FAIL reset_cfg_ports: start_adr=%h, need 0", start_adr);
        end
    endtask

    task automatic test_cfg_regs();
        logic [31:0] r, e;
        int c;
        for (int n = 0; n < NCH; n++) begin
            for (int k = 0; k < 3; k++) begin
                m_cfg[n][k] = $urandom;
                wr(ch_adr(n, k + 1), m_cfg[n][k]);
            end
            tx_cnt[n*32 +: 32] = $urandom;
        end
        for (int n = 0; n < NCH; n++) begin
            for (int k = 0; k < 3; k++) begin
                rd(ch_adr(n, k + 1), r); checks++;
                if (r !== m_cfg[n][k]) begin errors++; $display("FAIL cfg_rd ch%0d reg%0d: got %h need %h", n, k + 1, r, m_cfg[n][k]); end
            end
            checks++;
            if (start_adr[n*32 +: 32] !== m_cfg[n][0] || buf_size[n*32 +: 32] !== m_cfg[n][1] ||
                burst_size[n*32 +: 32] !== m_cfg[n][2]) begin
                errors++; $display("FAIL cfg_ports ch%0d: start_adr=%h need %h", n, start_adr[n*32 +: 32], m_cfg[n][0]);
            end
            e = tx_cnt[n*32 +: 32] * 32'd4;
            rd(ch_adr(n, R_TX), r); checks++;
            if (r !== e) begin errors++; $display("FAIL tx_bytes ch%0d: got %h need %h", n, r, e); end
        end
        m_mask = 4'($urandom_range(0, 15));
        wr(A_MASK, {28'd0, m_mask});
        rd(A_MASK, r); checks++;
        if (r !== {28'd0, m_mask}) begin errors++; $display("FAIL mask_rw: got %h need %h", r, m_mask); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mask_no_status_irq: got %b need 0", irq); end
        m_mask = '0;
        wr(A_MASK, 32'd0);
        c = $urandom_range(0, NCH - 1);
        wr(ch_adr(c, R_CTRL), 32'h2);
        rd(ch_adr(c, R_CTRL), r); checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL ctrl_cont_rw ch%0d: got %h need 2", c, r); end
        wr(ch_adr(c, R_CTRL), 32'h0);
    endtask

    task automatic test_one_shot();
        logic [31:0] r;
        logic found, irq_at, irq_next;
        int base;
        m_cfg[1][0] = 32'h1000;
        wr(ch_adr(1, 1), 32'h1000);
        m_mask = 4'h2;
        wr(A_MASK, 32'h2);
        base = en_cnt[1];
        wr(ch_adr(1, R_CTRL), 32'h1);
        checks++;
        if (enable !== 4'b0010) begin errors++; $display("FAIL start_enable_pulse: got %b need 0010", enable); end
        cycles(1);
        checks++;
        if (enable !== 4'b0000) begin errors++; $display("FAIL start_enable_width: got %b need 0000", enable); end
        rd(ch_adr(1, R_CTRL), r); checks++;
        if (r !== 32'h100) begin errors++; $display("FAIL one_shot_arm: got %h need 100", r); end
        busy[1] = 1'b1;
        cycles(2);
        rd(ch_adr(1, R_CTRL), r); checks++;
        if (r !== 32'h200) begin errors++; $display("FAIL one_shot_run: got %h need 200", r); end
        cycles(1);
        wb_adr_i = A_STATUS;
        busy[1] = 1'b0;
        found = 1'b0; irq_at = 1'bx; irq_next = 1'bx;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (wb_dat_o[1] === 1'b1) begin
                found = 1'b1; irq_at = irq;
                @(negedge clk);
                irq_next = irq;
            end
        end
        @(posedge clk);
        #1;
        m_status[1] = 1'b1; m_done[1]++;
        checks++;
        if (!found || irq_at !== 1'b0 || irq_next !== 1'b1) begin
            errors++; $display("FAIL irq_latency: status_seen=%b irq_same=%b irq_next=%b need 1 0 1", found, irq_at, irq_next);
        end
        rd(A_STATUS, r); checks++;
        if (r !== {28'd0, m_status}) begin errors++; $display("FAIL one_shot_status: got %h need %h", r, m_status); end
        rd(ch_adr(1, R_DONE), r); checks++;
        if (r !== 32'(m_done[1])) begin errors++; $display("FAIL one_shot_done_cnt: got %0d need %0d", r, m_done[1]); end
        rd(ch_adr(1, R_CTRL), r); checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL one_shot_idle: got %h need 0", r); end
        checks++;
        if (en_cnt[1] - base !== 1 || start_adr[32 +: 32] !== 32'h1000) begin
            errors++; $display("FAIL one_shot_pulses: pulses=%0d start_adr=%h need 1 and 1000", en_cnt[1] - base, start_adr[32 +: 32]);
        end
        wr(A_STATUS, 32'h2);
        m_status[1] = 1'b0;
        cycles(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b need 0", irq); end
        rd(A_STATUS, r); checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL w1c_status: got %h need 0", r); end
    endtask

    task automatic test_continuous();
        logic [31:0] r;
        int base;
        m_mask = '0;
        wr(A_MASK, 32'd0);
        base = en_cnt[0];
        wr(ch_adr(0, R_CTRL), 32'h3);
        for (int p = 0; p < 3; p++) begin
            busy[0] = 1'b1;
            cycles($urandom_range(2, 6));
            if (p == 2) wr(ch_adr(0, R_CTRL), 32'h6);
            busy[0] = 1'b0;
            m_done[0]++; m_status[0] = 1'b1;
            cycles(3);
        end
        cycles(4);
        checks++;
        if (en_cnt[0] - base !== 3) begin errors++; $display("FAIL cont_pulses: got %0d need 3", en_cnt[0] - base); end
        rd(ch_adr(0, R_DONE), r); checks++;
        if (r !== 32'(m_done[0])) begin errors++; $display("FAIL cont_done_cnt: got %0d need %0d", r, m_done[0]); end
        rd(ch_adr(0, R_CTRL), r); checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL cont_abort_idle: got %h need 2", r); end
        rd(A_STATUS, r); checks++;
        if (r !== {28'd0, m_status}) begin errors++; $display("FAIL cont_status: got %h need %h", r, m_status); end
        wr(A_STATUS, 32'hF);
        m_status = '0;
        wr(ch_adr(0, R_CTRL), 32'h0);
    endtask

    task automatic test_start_ign();
        logic [31:0] r;
        int base;
        base = en_cnt[2];
        wr(ch_adr(2, R_CTRL), 32'h5);
        cycles(2);
        rd(ch_adr(2, R_CTRL), r); checks++;
        if (r[9:8] !== 2'd0 || en_cnt[2] !== base) begin
            errors++; $display("FAIL start_abort_same_write: state=%0d pulses=%0d need 0 0", r[9:8], en_cnt[2] - base);
        end
        wr(ch_adr(2, R_CTRL), 32'h1);
        busy[2] = 1'b1;
        cycles(2);
        base = en_cnt[2];
        wr(ch_adr(2, R_CTRL), 32'h1);
        cycles(2);
        checks++;
        if (en_cnt[2] !== base) begin errors++; $display("FAIL start_in_run_pulse: got %0d extra pulses need 0", en_cnt[2] - base); end
        rd(ch_adr(2, R_CTRL), r); checks++;
        if (r !== 32'h0001_0200) begin errors++; $display("FAIL start_ign_set: got %h need 00010200", r); end
        wr(ch_adr(2, R_CTRL), 32'h0001_0000);
        rd(ch_adr(2, R_CTRL), r); checks++;
        if (r !== 32'h200) begin errors++; $display("FAIL start_ign_clear: got %h need 200", r); end
        busy[2] = 1'b0;
        m_done[2]++; m_status[2] = 1'b1;
        cycles(3);
        rd(ch_adr(2, R_DONE), r); checks++;
        if (r !== 32'(m_done[2])) begin errors++; $display("FAIL ign_done_cnt: got %0d need %0d", r, m_done[2]); end
        rd(A_STATUS, r); checks++;
        if (r !== {28'd0, m_status}) begin errors++; $display("FAIL ign_status: got %h need %h", r, m_status); end
        wr(A_STATUS, 32'hF);
        m_status = '0;
    endtask

    task automatic test_unmapped();
        logic [31:0] r;
        logic [7:0] a;
        logic got_ack, got_err;
        m_mask = 4'($urandom_range(1, 15));
        wr(A_MASK, {28'd0, m_mask});
        for (int i = 0; i < 6; i++) begin
            case (i % 3)
                0: a = (i == 0) ? 8'hA0 : {3'($urandom_range(NCH + 1, 7)), 3'($urandom_range(0, 7)), 2'b00};
                1: a = {3'd0, 3'($urandom_range(4, 7)), 2'b00};
                default: a = {3'($urandom_range(1, NCH)), 3'($urandom_range(6, 7)), 2'b00};
            endcase
            bus(a, 1'b1, $urandom, r, got_ack, got_err); checks++;
            if (got_err !== 1'b1 || got_ack !== 1'b0) begin
                errors++; $display("FAIL unmapped_wr adr=%h: ack=%b err=%b need 0 1", a, got_ack, got_err);
            end
            checks++;
            if (wb_err_o !== 1'b0) begin errors++; $display("FAIL err_one_cycle adr=%h: err=%b need 0", a, wb_err_o); end
            bus(a, 1'b0, 32'd0, r, got_ack, got_err); checks++;
            if (got_err !== 1'b1 || got_ack !== 1'b0 || r !== 32'd0) begin
                errors++; $display("FAIL unmapped_rd adr=%h: ack=%b err=%b data=%h need 0 1 0", a, got_ack, got_err, r);
            end
        end
        rd(A_MASK, r); checks++;
        if (r !== {28'd0, m_mask}) begin errors++; $display("FAIL unmapped_mask_kept: got %h need %h", r, m_mask); end
        for (int n = 0; n < NCH; n++) begin
            for (int k = 0; k < 3; k++) begin
                rd(ch_adr(n, k + 1), r); checks++;
                if (r !== m_cfg[n][k]) begin errors++; $display("FAIL unmapped_cfg_kept ch%0d reg%0d: got %h need %h", n, k + 1, r, m_cfg[n][k]); end
            end
        end
        m_mask = '0;
        wr(A_MASK, 32'd0);
    endtask

    task automatic test_w1c_race();
        logic [31:0] r;
        wr(ch_adr(3, R_CTRL), 32'h1);
        busy[3] = 1'b1;
        cycles(3);
        wb_adr_i = A_STATUS; wb_we_i = 1'b1; wb_dat_i = 32'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        cycles(1);
        checks++;
        if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL race_ack_timing: ack=%b need 1", wb_ack_o); end
        busy[3] = 1'b0;
        cycles(1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        m_status[3] = 1'b1; m_done[3]++;
        rd(A_STATUS, r); checks++;
        if (r !== {28'd0, m_status}) begin errors++; $display("FAIL w1c_set_wins: got %h need %h", r, m_status); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int base;
        m_mask = 4'h8;
        wr(A_MASK, 32'h8);
        cycles(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b need 1", irq); end
        wr(ch_adr(3, R_CTRL), 32'h3);
        busy[3] = 1'b1;
        cycles(3);
        rd(ch_adr(3, R_CTRL), r); checks++;
        if (r !== 32'h202) begin errors++; $display("FAIL pre_reset_run: got %h need 202", r); end
        rst = 1'b1;
        cycles(1);
        checks++;
        if (enable !== '0 || irq !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: enable=%b irq=%b need 0 0", enable, irq); end
        rst = 1'b0;
        model_reset();
        base = en_cnt[3];
        for (int n = 0; n < NCH; n++) begin
            rd(ch_adr(n, R_CTRL), r); checks++;
            if (r !== 32'd0) begin errors++; $display("FAIL mid_reset_idle ch%0d: got %h need 0", n, r); end
        end
        busy[3] = 1'b0;
        cycles(4);
        rd(A_STATUS, r); checks++;
        if (r !== 32'd0 || irq !== 1'b0) begin errors++; $display("FAIL post_reset_fall: status=%h irq=%b need 0 0", r, irq); end
        rd(ch_adr(3, R_DONE), r); checks++;
        if (r !== 32'd0 || en_cnt[3] !== base) begin
            errors++; $display("FAIL post_reset_quiet: done_cnt=%0d pulses=%0d need 0 0", r, en_cnt[3] - base);
        end
        checks++;
        if (start_adr !== '0) begin errors++; $display("FAIL post_reset_cfg: start_adr=%h need 0", start_adr); end
    endtask

    initial begin
        #1;
        test_reset();
        test_cfg_regs();
        test_one_shot();
        test_continuous();
        test_start_ign();
        test_unmapped();
        test_w1c_race();
        test_reset_mid();
        checks++;
        if (dbl_pulse !== 0) begin errors++; $display("FAIL enable_width: %0d multi-cycle pulses, need 0", dbl_pulse); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
